// File: rtl/float_adder_arbiter.sv
// Round-robin front end that shares one combinational FP32 adder among NUM_REQ requesters,
// with an operand stage (S1) feeding a result register (S2) under valid/ready flow control.

module high_level_float_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  logic        swap, sub, a_nan, b_nan, a_inf, b_inf, found, up;
  logic [31:0] big, sml;
  logic [7:0]  e_big, e_sml, d, exp_field;
  logic [23:0] m_big, m_sml;
  logic [27:0] x_big, x_sml, x_sh, mask, s_raw, s_c, s_n;
  logic [8:0]  exp_c, exp_n, sh9;
  logic [4:0]  lz;
  logic [30:0] rounded;

  always_comb begin
    a_nan = (a_i[30:23] == 8'hff) && (a_i[22:0] != '0);
    b_nan = (b_i[30:23] == 8'hff) && (b_i[22:0] != '0);
    a_inf = (a_i[30:23] == 8'hff) && (a_i[22:0] == '0);
    b_inf = (b_i[30:23] == 8'hff) && (b_i[22:0] == '0);

    swap  = b_i[30:0] > a_i[30:0];
    big   = swap ? b_i : a_i;
    sml   = swap ? a_i : b_i;
    // Subnormals share the exponent of the smallest normal, without the hidden bit.
    e_big = (big[30:23] == '0) ? 8'd1 : big[30:23];
    e_sml = (sml[30:23] == '0) ? 8'd1 : sml[30:23];
    m_big = {|big[30:23], big[22:0]};
    m_sml = {|sml[30:23], sml[22:0]};
    sub   = big[31] ^ sml[31];
    d     = e_big - e_sml;

    x_big = {1'b0, m_big, 3'b000};
    x_sml = {1'b0, m_sml, 3'b000};
    mask  = '0;
    if (d > 8'd27) begin
      x_sh = {27'd0, |m_sml};
    end else begin
      mask = (28'd1 << d[4:0]) - 28'd1;
      x_sh = (x_sml >> d[4:0]) | {27'd0, |(x_sml & mask)};
    end

    s_raw = sub ? (x_big - x_sh) : (x_big + x_sh);
    exp_c = {1'b0, e_big};
    s_c   = s_raw;
    if (s_raw[27]) begin
      s_c   = {1'b0, s_raw[27:1]} | {27'd0, s_raw[0]};
      exp_c = exp_c + 9'd1;
    end

    lz    = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && s_c[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    // Normalisation may not push the exponent below 1; what remains is subnormal.
    sh9   = ({4'd0, lz} > (exp_c - 9'd1)) ? (exp_c - 9'd1) : {4'd0, lz};
    s_n   = s_c << sh9;
    exp_n = exp_c - sh9;

    up        = s_n[2] & (s_n[1] | s_n[0] | s_n[3]);
    exp_field = s_n[26] ? exp_n[7:0] : 8'd0;
    rounded   = {exp_field, s_n[25:3]} + {30'd0, up};

    if (a_nan || b_nan || (a_inf && b_inf && (a_i[31] != b_i[31]))) begin
      sum_o = 32'h7fc0_0000;
    end else if (a_inf) begin
      sum_o = a_i;
    end else if (b_inf) begin
      sum_o = b_i;
    end else if (s_raw == '0) begin
      sum_o = {sub ? 1'b0 : big[31], 31'd0};
    end else if (exp_n >= 9'd255) begin
      sum_o = {big[31], 8'hff, 23'd0};
    end else begin
      sum_o = {big[31], rounded};
    end
  end

endmodule

module float_adder_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  res_valid,
  output logic [31:0]           res_data,
  output logic [ID_W-1:0]       res_id,
  input  logic                  res_ready,
  output logic [CNT_W-1:0]      op_count
);

  logic              s1_valid_q, s1_valid_d;
  logic [31:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [ID_W-1:0]   s1_id_q, s1_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              res_valid_q, res_valid_d;
  logic [31:0]       res_data_q, res_data_d;
  logic [ID_W-1:0]   res_id_q, res_id_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              s1_adv, s1_acc, gnt_any, gnt;
  logic [ID_W-1:0]   gnt_idx;
  logic [31:0]       idx;
  logic [31:0]       sum;

  high_level_float_adder u_adder (
    .a_i  (s1_a_q),
    .b_i  (s1_b_q),
    .sum_o(sum)
  );

  assign s1_adv = s1_valid_q && (!res_valid_q || res_ready);
  assign s1_acc = !s1_valid_q || s1_adv;

  // Circular search starting at the round-robin pointer.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!gnt_any && req_valid[ID_W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
    gnt       = gnt_any && s1_acc && !rst;
    req_ready = gnt ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_id_d     = s1_id_q;
    ptr_d       = ptr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, res_valid_q && res_ready};

    if (gnt) begin
      s1_valid_d = 1'b1;
      s1_a_d     = req_a[32*gnt_idx +: 32];
      s1_b_d     = req_b[32*gnt_idx +: 32];
      s1_id_d    = gnt_idx;
      ptr_d      = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      res_valid_d = 1'b1;
      res_data_d  = sum;
      res_id_d    = s1_id_q;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_id_q     <= '0;
      ptr_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_id_q     <= s1_id_d;
      ptr_q       <= ptr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      op_count_q  <= op_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_float_adder_arbiter.sv
// Bench for float_adder_arbiter: FP vector table, directed flow-control sequences and a
// randomized run checked against a queue-based model with a real-valued FP32 reference.

module tb_float_adder_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic         res_valid;
  logic [31:0]  res_data;
  logic [1:0]   res_id;
  logic         res_ready;
  logic [3:0]   op_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    bit          vis;
  } op_t;

  vec_t vecs[14];
  op_t  q[$];

  float_adder_arbiter #(.NUM_REQ(4), .CNT_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_id   (res_id),
    .res_ready(res_ready),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst       = 1'b1;
    req_valid = '0;
    res_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic real f2r(input logic [31:0] x);
    return $bitstoreal({x[31], 11'({3'b0, x[30:23]}) + 11'd896, x[22:0], 29'd0});
  endfunction

  // Normal operands only; sums are exact in double, then rounded to nearest-even FP32.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    real         r;
    logic [63:0] dd;
    logic [8:0]  fe;
    logic [23:0] m;
    r = f2r(a) + f2r(b);
    if (r == 0.0) return 32'h0;
    dd = $realtobits(r);
    fe = 9'(dd[62:52] - 11'd896);
    m  = {1'b0, dd[51:29]};
    if (dd[28] && ((|dd[27:0]) || m[0])) m = m + 24'd1;
    if (m[23]) begin
      fe = fe + 9'd1;
      m  = '0;
    end
    return {dd[63], fe[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(134, 120));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_sum, input string name);
    int n;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    req_valid          = 4'(1 << id);
    res_ready          = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk({name, "_grant_timeout"}, 32'(n >= 20), 32'd0);
    tick();
    req_valid = '0;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_res_timeout"}, 32'(n >= 20), 32'd0);
    chk({name, "_data"}, res_data, exp_sum);
    chk({name, "_id"}, 32'(res_id), 32'(id));
    tick();
  endtask

  initial begin
    int grants, results, first, g, cnt, ptr;
    bit out_valid, pending, advance, accept;
    logic [3:0] rv;
    op_t t;

    vecs[0]  = '{2, 32'h3f80_0000, 32'h4000_0000, 32'h4040_0000};
    vecs[1]  = '{0, 32'h4080_0000, 32'h3f00_0000, 32'h4090_0000};
    vecs[2]  = '{1, 32'h3f80_0000, 32'hbf80_0000, 32'h0000_0000};
    vecs[3]  = '{3, 32'h7f80_0000, 32'h3f80_0000, 32'h7f80_0000};
    vecs[4]  = '{0, 32'h7f80_0000, 32'hff80_0000, 32'h7fc0_0000};
    vecs[5]  = '{1, 32'h7fc0_0001, 32'h3f80_0000, 32'h7fc0_0000};
    vecs[6]  = '{2, 32'h7f7f_ffff, 32'h7f7f_ffff, 32'h7f80_0000};
    vecs[7]  = '{3, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002};
    vecs[8]  = '{0, 32'h0080_0000, 32'h8000_0001, 32'h007f_ffff};
    vecs[9]  = '{1, 32'h3f80_0000, 32'h3380_0000, 32'h3f80_0000};
    vecs[10] = '{2, 32'h3f80_0000, 32'h33c0_0000, 32'h3f80_0001};
    vecs[11] = '{3, 32'h3f80_0001, 32'h3380_0000, 32'h3f80_0002};
    vecs[12] = '{0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[13] = '{1, 32'hc040_0000, 32'h3f80_0000, 32'hc000_0000};

    clk       = 1'b0;
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    tick();
    tick();

    // Reset state, with requests pending while reset is held.
    req_valid = 4'hf;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    rst       = 1'b0;
    req_valid = '0;
    #1;
    chk("idle_req_ready", 32'(req_ready), 32'd0);

    // Single op latency: grant in cycle N, result in N+2, count in N+3.
    req_a[64 +: 32] = 32'h3f80_0000;
    req_b[64 +: 32] = 32'h4000_0000;
    req_valid       = 4'b0100;
    res_ready       = 1'b1;
    #1;
    chk("single_grant", 32'(req_ready), 32'h4);
    tick();
    req_valid = '0;
    chk("single_n1_valid", 32'(res_valid), 32'd0);
    tick();
    chk("single_n2_valid", 32'(res_valid), 32'd1);
    chk("single_n2_data", res_data, 32'h4040_0000);
    chk("single_n2_id", 32'(res_id), 32'd2);
    chk("single_n2_count", 32'(op_count), 32'd0);
    tick();
    chk("single_n3_count", 32'(op_count), 32'd1);
    chk("single_n3_valid", 32'(res_valid), 32'd0);

    foreach (vecs[i]) do_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, $sformatf("vec%0d", i));

    // Round-robin fairness with all requesters active.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = 32'h3f80_0000;
      req_b[32*i +: 32] = 32'h3f80_0000;
    end
    req_valid = 4'hf;
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_grant%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      if (c >= 2) begin
        chk($sformatf("rr_valid%0d", c), 32'(res_valid), 32'd1);
        chk($sformatf("rr_id%0d", c), 32'(res_id), 32'(c - 2));
      end
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    tick();

    // Backpressure: three stalled cycles after the first result.
    reset_dut();
    req_a[0 +: 32] = 32'h4080_0000;
    req_b[0 +: 32] = 32'h3f00_0000;
    grants  = 0;
    results = 0;
    first   = -1;
    for (int c = 0; c < 40; c++) begin
      req_valid = (grants < 8) ? 4'b0001 : 4'b0000;
      if (first < 0 && res_valid) first = c;
      res_ready = (first < 0) || (c >= first + 3);
      #1;
      if (first >= 0 && c < first + 3) begin
        chk($sformatf("bp_hold_valid%0d", c), 32'(res_valid), 32'd1);
        chk($sformatf("bp_hold_data%0d", c), res_data, 32'h4090_0000);
        chk($sformatf("bp_stall_ready%0d", c), 32'(req_ready), 32'd0);
      end
      if (req_ready[0]) grants++;
      if (res_valid && res_ready) begin
        results++;
        chk("bp_data", res_data, 32'h4090_0000);
        chk("bp_id", 32'(res_id), 32'd0);
      end
      tick();
    end
    chk("bp_grants", 32'(grants), 32'd8);
    chk("bp_results", 32'(results), 32'(grants));

    // Pointer skip and wrap.
    reset_dut();
    res_ready = 1'b1;
    req_valid = 4'b0100;
    #1;
    chk("ptr_g2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0010;
    #1;
    chk("ptr_skip_g1", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b1000;
    #1;
    chk("ptr_g3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b1111;
    #1;
    chk("ptr_wrap_g0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();

    // Reset while both stages hold operations.
    reset_dut();
    do_op(0, 32'h3f80_0000, 32'h3f80_0000, 32'h4000_0000, "mid_pre");
    chk("mid_count_before", 32'(op_count), 32'd1);
    res_ready = 1'b0;
    req_valid = 4'hf;
    #1;
    chk("mid_fill_g1", 32'(req_ready), 32'h2);
    tick();
    #1;
    chk("mid_fill_g2", 32'(req_ready), 32'h4);
    tick();
    #1;
    chk("mid_full_ready", 32'(req_ready), 32'd0);
    chk("mid_full_valid", 32'(res_valid), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    rst       = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    res_ready = 1'b1;
    tick();
    tick();
    tick();

    // Counter wrap with a 4-bit count.
    reset_dut();
    req_a[32 +: 32] = 32'h3f80_0000;
    req_b[32 +: 32] = 32'h3f80_0000;
    res_ready = 1'b1;
    grants    = 0;
    results   = 0;
    for (int c = 0; c < 40; c++) begin
      req_valid = (grants < 17) ? 4'b0010 : 4'b0000;
      #1;
      if (req_ready[1]) grants++;
      if (res_valid) begin
        results++;
        chk("wrap_data", res_data, 32'h4000_0000);
      end
      tick();
    end
    chk("wrap_results", 32'(results), 32'd17);
    chk("wrap_count", 32'(op_count), 32'd1);

    // Randomized traffic against the queue model.
    reset_dut();
    q.delete();
    ptr = 0;
    cnt = 0;
    for (int c = 0; c < 400; c++) begin
      rv        = 4'($urandom_range(15, 0));
      req_valid = rv;
      res_ready = ($urandom_range(3, 0) != 0);
      for (int i = 0; i < 4; i++) begin
        req_a[32*i +: 32] = rand_fp();
        req_b[32*i +: 32] = rand_fp();
      end
      #1;
      out_valid = (q.size() > 0) && q[0].vis;
      pending   = (q.size() > 0) && !q[q.size()-1].vis;
      advance   = pending && (!out_valid || res_ready);
      accept    = !pending || advance;
      g = -1;
      if (accept) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && rv[(ptr + k) % 4]) g = (ptr + k) % 4;
        end
      end
      chk("rnd_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
      chk("rnd_valid", 32'(res_valid), 32'(out_valid));
      chk("rnd_count", 32'(op_count), 32'(cnt));
      if (out_valid) begin
        chk("rnd_data", res_data, ref_add(q[0].a, q[0].b));
        chk("rnd_id", 32'(res_id), 32'(q[0].id));
      end
      if (out_valid && res_ready) begin
        void'(q.pop_front());
        cnt = (cnt + 1) % 16;
      end
      if (advance) begin
        t     = q[q.size()-1];
        t.vis = 1'b1;
        q[q.size()-1] = t;
      end
      if (g >= 0) begin
        q.push_back('{req_a[32*g +: 32], req_b[32*g +: 32], g, 1'b0});
        ptr = (g + 1) % 4;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
